lsu_mem_stage: RTL and testbench

LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

---
 rtl/lsu_mem_stage.sv | 181 ++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// Load/store unit MEM stage: D-cache handshake, sub-word load extraction and
// read-modify-write for SB/SH. Optional misaligned trap via LSU_MISALIGN_TRAP_EN.
module lsu_mem_stage #(
  parameter int BIT_W   = 32,
  parameter bit SUBWORD = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [BIT_W-1:0] alu_result_in,
  input  logic [BIT_W-1:0] mem_wdata_in,
  input  logic [BIT_W-1:0] PC_plus_4_in,
  input  logic [2:0]       funct3_in,
  input  logic             memrd_in,
  input  logic             memwr_in,
  input  logic             mem2reg_in,
  input  logic             regwr_in,
  input  logic [4:0]       rd_in,
  output logic [BIT_W-1:0] alu_result_out,
  output logic [BIT_W-1:0] mem_dat,
  output logic [BIT_W-1:0] PC_plus_4_out,
  output logic [4:0]       rd_out,
  output logic             mem2reg_out,
  output logic             regwr_out,
  output logic             valid_out,
  output logic             misalign_out,
  output logic             DCACHE_ren,
  output logic             DCACHE_wen,
  output logic [BIT_W-3:0] DCACHE_addr,
  output logic [BIT_W-1:0] DCACHE_wdata,
  input  logic [BIT_W-1:0] DCACHE_rdata,
  input  logic             DCACHE_stall,
  output logic             mem_stall
);

  typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} state_t;

  state_t           state, state_nxt;
  logic             rmw_done;
  logic [BIT_W-1:0] merge_q;
  logic [2:0]       f3;
  logic [1:0]       lane;
  logic             is_load, is_store, sub_store, mis, rmw_start;
  logic             ren_c, wen_c;
  logic [BIT_W-1:0] wdata_c;

  function automatic logic [BIT_W-1:0] load_ext(input logic [BIT_W-1:0] w,
                                               input logic [2:0] fn,
                                               input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (fn)
      3'b000:  load_ext = {{(BIT_W-8){b[7]}}, b};
      3'b100:  load_ext = {{(BIT_W-8){1'b0}}, b};
      3'b001:  load_ext = {{(BIT_W-16){h[15]}}, h};
      3'b101:  load_ext = {{(BIT_W-16){1'b0}}, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [BIT_W-1:0] merge_word(input logic [BIT_W-1:0] w,
                                                 input logic [BIT_W-1:0] d,
                                                 input logic [2:0] fn,
                                                 input logic [1:0] a);
    merge_word = w;
    if (fn[1:0] == 2'b00) begin
      case (a)
        2'd0:    merge_word[7:0]   = d[7:0];
        2'd1:    merge_word[15:8]  = d[7:0];
        2'd2:    merge_word[23:16] = d[7:0];
        default: merge_word[31:24] = d[7:0];
      endcase
    end else if (a[1]) begin
      merge_word[31:16] = d[15:0];
    end else begin
      merge_word[15:0] = d[15:0];
    end
  endfunction

  // With SUBWORD=0 every access behaves as a word access.
  assign f3        = SUBWORD ? funct3_in : 3'b010;
  assign lane      = alu_result_in[1:0];
  assign is_store  = valid_in & memwr_in;
  assign is_load   = valid_in & memrd_in & ~memwr_in;
  assign sub_store = is_store & SUBWORD & (f3[1:0] == 2'b00 || f3[1:0] == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = (is_load | is_store) &
               (((f3[1:0] == 2'b01) & lane[0]) | ((f3[1:0] == 2'b10) & (|lane)));
`else
  assign mis = 1'b0;
`endif

  // rmw_done blocks a restart of the same store while it retires from IDLE.
  assign rmw_start = (state == IDLE) & sub_store & ~mis & ~rmw_done;
  assign mem_stall = DCACHE_stall | (state != IDLE) | rmw_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rmw_start) state_nxt = DCACHE_stall ? RMW_RD : RMW_WR;
      RMW_RD:  if (!DCACHE_stall) state_nxt = RMW_WR;
      RMW_WR:  if (!DCACHE_stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ren_c   = 1'b0;
    wen_c   = 1'b0;
    wdata_c = mem_wdata_in;
    case (state)
      IDLE: begin
        if (rmw_start)                      ren_c = 1'b1;
        else if (!mis && !sub_store) begin
          if (is_store)     wen_c = 1'b1;
          else if (is_load) ren_c = 1'b1;
        end
      end
      RMW_RD: ren_c = 1'b1;
      RMW_WR: begin
        wen_c   = 1'b1;
        wdata_c = merge_q;
      end
      default: ;
    endcase
  end

  assign DCACHE_ren   = ren_c & rst_n;
  assign DCACHE_wen   = wen_c & rst_n;
  assign DCACHE_wdata = wdata_c;
  assign DCACHE_addr  = alu_result_in[BIT_W-1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      merge_q  <= '0;
      rmw_done <= 1'b0;
    end else begin
      if ((rmw_start || state == RMW_RD) && !DCACHE_stall)
        merge_q <= merge_word(DCACHE_rdata, mem_wdata_in, f3, lane);
      if (state == RMW_WR && !DCACHE_stall) rmw_done <= 1'b1;
      else if (!mem_stall)                  rmw_done <= 1'b0;
    end
  end

  // MEM/WB boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_out <= '0;
      mem_dat        <= '0;
      PC_plus_4_out  <= '0;
      rd_out         <= '0;
      mem2reg_out    <= 1'b0;
      regwr_out      <= 1'b0;
      valid_out      <= 1'b0;
      misalign_out   <= 1'b0;
    end else if (!mem_stall) begin
      alu_result_out <= alu_result_in;
      mem_dat        <= (is_load && !mis) ? load_ext(DCACHE_rdata, f3, lane) : '0;
      PC_plus_4_out  <= PC_plus_4_in;
      rd_out         <= rd_in;
      mem2reg_out    <= mem2reg_in;
      regwr_out      <= valid_in & regwr_in & ~mis;
      valid_out      <= valid_in;
      misalign_out   <= mis;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: loads, sub-word RMW stores, cache stall,
// reset mid-RMW and (when LSU_MISALIGN_TRAP_EN is defined) misaligned trap.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] alu_result_in, mem_wdata_in, PC_plus_4_in;
  logic [2:0]  funct3_in;
  logic        memrd_in, memwr_in, mem2reg_in, regwr_in;
  logic [4:0]  rd_in;
  logic [31:0] alu_result_out, mem_dat, PC_plus_4_out;
  logic [4:0]  rd_out;
  logic        mem2reg_out, regwr_out, valid_out, misalign_out;
  logic        DCACHE_ren, DCACHE_wen;
  logic [29:0] DCACHE_addr;
  logic [31:0] DCACHE_wdata, DCACHE_rdata;
  logic        DCACHE_stall;
  logic        mem_stall;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.BIT_W(32), .SUBWORD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .alu_result_in(alu_result_in), .mem_wdata_in(mem_wdata_in), .PC_plus_4_in(PC_plus_4_in),
    .funct3_in(funct3_in), .memrd_in(memrd_in), .memwr_in(memwr_in),
    .mem2reg_in(mem2reg_in), .regwr_in(regwr_in), .rd_in(rd_in),
    .alu_result_out(alu_result_out), .mem_dat(mem_dat), .PC_plus_4_out(PC_plus_4_out),
    .rd_out(rd_out), .mem2reg_out(mem2reg_out), .regwr_out(regwr_out),
    .valid_out(valid_out), .misalign_out(misalign_out),
    .DCACHE_ren(DCACHE_ren), .DCACHE_wen(DCACHE_wen), .DCACHE_addr(DCACHE_addr),
    .DCACHE_wdata(DCACHE_wdata), .DCACHE_rdata(DCACHE_rdata),
    .DCACHE_stall(DCACHE_stall), .mem_stall(mem_stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic v, input logic rd_en, input logic wr_en,
                        input logic [2:0] fn, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd);
    valid_in      = v;
    memrd_in      = rd_en;
    memwr_in      = wr_en;
    mem2reg_in    = rd_en & ~wr_en;
    regwr_in      = rd_en & ~wr_en;
    funct3_in     = fn;
    alu_result_in = addr;
    mem_wdata_in  = wd;
    PC_plus_4_in  = addr + 32'd4;
    rd_in         = rd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    DCACHE_stall = 1'b0;
    DCACHE_rdata = 32'h0;
    set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd1);
    #12;
    chk("rst_ren", {31'b0, DCACHE_ren}, 32'h0);
    chk("rst_wen", {31'b0, DCACHE_wen}, 32'h0);
    chk("rst_valid_out", {31'b0, valid_out}, 32'h0);
    chk("rst_regwr_out", {31'b0, regwr_out}, 32'h0);
    chk("rst_mem_dat", mem_dat, 32'h0);
    chk("rst_misalign", {31'b0, misalign_out}, 32'h0);
    rst_n = 1'b1;

    // LW 0x100
    set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd3);
    DCACHE_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_ren", {31'b0, DCACHE_ren}, 32'h1);
    chk("lw_addr", {2'b0, DCACHE_addr}, 32'h40);
    chk("lw_stall", {31'b0, mem_stall}, 32'h0);
    tick;
    chk("lw_dat", mem_dat, 32'hDEADBEEF);
    chk("lw_rd", {27'b0, rd_out}, 32'd3);
    chk("lw_regwr", {31'b0, regwr_out}, 32'h1);
    chk("lw_pc4", PC_plus_4_out, 32'h104);

    // Sub-word loads of 0x80112233
    DCACHE_rdata = 32'h80112233;
    set_op(1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd4); tick;
    chk("lb_dat", mem_dat, 32'hFFFFFF80);
    set_op(1'b1, 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd4); tick;
    chk("lbu_dat", mem_dat, 32'h00000080);
    set_op(1'b1, 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd4); tick;
    chk("lh_hi_dat", mem_dat, 32'hFFFF8011);
    set_op(1'b1, 1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 5'd4); tick;
    chk("lh_lo_dat", mem_dat, 32'h00002233);
    set_op(1'b1, 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 5'd4); tick;
    chk("lhu_dat", mem_dat, 32'h00008011);

    // LW under 3 cycles of cache stall
    DCACHE_rdata = 32'hAAAA5555;
    DCACHE_stall = 1'b1;
    set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd6);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stl_ren", {31'b0, DCACHE_ren}, 32'h1);
      chk("stl_addr", {2'b0, DCACHE_addr}, 32'h80);
      chk("stl_mstall", {31'b0, mem_stall}, 32'h1);
      tick;
      chk("stl_hold_dat", mem_dat, 32'h00008011);
    end
    DCACHE_stall = 1'b0;
    #1;
    chk("stl_ren4", {31'b0, DCACHE_ren}, 32'h1);
    chk("stl_mstall4", {31'b0, mem_stall}, 32'h0);
    tick;
    chk("stl_dat", mem_dat, 32'hAAAA5555);

    // SB 0x101 into 0x11223344
    DCACHE_rdata = 32'h11223344;
    set_op(1'b1, 1'b0, 1'b1, 3'b000, 32'h101, 32'h000000AB, 5'd0);
    #1;
    chk("sb_ren", {31'b0, DCACHE_ren}, 32'h1);
    chk("sb_wen0", {31'b0, DCACHE_wen}, 32'h0);
    chk("sb_stall1", {31'b0, mem_stall}, 32'h1);
    tick;
    chk("sb_wen", {31'b0, DCACHE_wen}, 32'h1);
    chk("sb_ren1", {31'b0, DCACHE_ren}, 32'h0);
    chk("sb_wdata", DCACHE_wdata, 32'h1122AB44);
    chk("sb_stall2", {31'b0, mem_stall}, 32'h1);
    chk("sb_hold_dat", mem_dat, 32'hAAAA5555);
    tick;
    chk("sb_stall3", {31'b0, mem_stall}, 32'h0);
    chk("sb_noacc", {30'b0, DCACHE_ren, DCACHE_wen}, 32'h0);
    tick;
    chk("sb_dat", mem_dat, 32'h0);
    chk("sb_valid", {31'b0, valid_out}, 32'h1);
    chk("sb_regwr", {31'b0, regwr_out}, 32'h0);

    // SH 0x102 (memrd also high: still a store)
    set_op(1'b1, 1'b1, 1'b1, 3'b001, 32'h102, 32'h0000BEEF, 5'd0);
    #1;
    chk("sh_ren", {31'b0, DCACHE_ren}, 32'h1);
    tick;
    chk("sh_wdata", DCACHE_wdata, 32'hBEEF3344);
    chk("sh_wen", {31'b0, DCACHE_wen}, 32'h1);
    tick;

    // SW with memrd also high
    set_op(1'b1, 1'b1, 1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 5'd0);
    #1;
    chk("sw_wen", {31'b0, DCACHE_wen}, 32'h1);
    chk("sw_ren", {31'b0, DCACHE_ren}, 32'h0);
    chk("sw_wdata", DCACHE_wdata, 32'hCAFEF00D);
    chk("sw_stall", {31'b0, mem_stall}, 32'h0);
    tick;

    // valid_in low suppresses access
    set_op(1'b0, 1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 5'd7);
    #1;
    chk("inv_acc", {30'b0, DCACHE_ren, DCACHE_wen}, 32'h0);
    tick;
    chk("inv_valid", {31'b0, valid_out}, 32'h0);
    chk("inv_regwr", {31'b0, regwr_out}, 32'h0);

    // Reset during RMW_WR
    set_op(1'b1, 1'b0, 1'b1, 3'b000, 32'h100, 32'h55, 5'd0);
    tick;
    chk("rrmw_wen", {31'b0, DCACHE_wen}, 32'h1);
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h100, 32'h0, 5'd0);
    rst_n = 1'b0;
    #1;
    chk("rrmw_wen_rst", {31'b0, DCACHE_wen}, 32'h0);
    chk("rrmw_stall", {31'b0, mem_stall}, 32'h0);
    chk("rrmw_valid", {31'b0, valid_out}, 32'h0);
    chk("rrmw_alu", alu_result_out, 32'h0);
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rrmw_nowen", {31'b0, DCACHE_wen}, 32'h0);
      chk("rrmw_idle", {31'b0, mem_stall}, 32'h0);
      tick;
    end

    // Misaligned LW
    DCACHE_rdata = 32'h12345678;
    set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 5'd9);
    #1;
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_ren", {31'b0, DCACHE_ren}, 32'h0);
    tick;
    chk("mis_flag", {31'b0, misalign_out}, 32'h1);
    chk("mis_regwr", {31'b0, regwr_out}, 32'h0);
`else
    chk("mis_ren", {31'b0, DCACHE_ren}, 32'h1);
    tick;
    chk("mis_flag", {31'b0, misalign_out}, 32'h0);
    chk("mis_dat", mem_dat, 32'h12345678);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
